key_step_counter: RTL and testbench

- Upstream source for the two-digit decimal display stage, which consumes a 4-bit binary value 0..15 and shows it as 00..15 on HEX1/HEX0.
- Turns two DE-board pushbuttons (increment/decrement) and a switch-driven parallel load into a registered 4-bit value.
- Includes synchronisation, debounce, single-step edge detection and wrap/saturate control.
- The display stage needs no changes; it connects to value[3:0].

---
 rtl/key_step_counter.sv | 167 ++++++++++++++++
 tb/tb_key_step_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_step_counter.sv
// Two-key up/down counter with synchroniser, debounce and press detect, feeding a 0..15 display.
// Optional per-key auto-repeat while a key is held is enabled by defining AUTO_REPEAT_EN.
module key_step_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 1,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       changed,
    output logic       wrap
);

    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the up key, bit 1 the down key.
    logic [1:0]       meta_r;
    logic [1:0]       sync_r;
    logic [1:0]       stable_r;
    logic [1:0]       stable_prev_r;
    logic [1:0][19:0] db_cnt_r;
    logic [1:0]       press_s;
    logic [1:0]       step_s;
    logic [3:0]       next_value_s;
    logic             next_changed_s;
    logic             next_wrap_s;

    // Two-flop synchroniser for the raw key levels.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
        end else begin
            meta_r <= {key_down_n, key_up_n};
            sync_r <= meta_r;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable_r      <= 2'b11;
            stable_prev_r <= 2'b11;
            db_cnt_r      <= '0;
        end else begin
            stable_prev_r <= stable_r;
            for (int k = 0; k < 2; k++) begin
                if (sync_r[k] != stable_r[k]) begin
                    if (db_cnt_r[k] == DB_LAST) begin
                        stable_r[k] <= sync_r[k];
                        db_cnt_r[k] <= 20'd0;
                    end else begin
                        db_cnt_r[k] <= db_cnt_r[k] + 20'd1;
                    end
                end else begin
                    db_cnt_r[k] <= 20'd0;
                end
            end
        end
    end

    assign press_s = stable_prev_r & ~stable_r;

`ifdef AUTO_REPEAT_EN
    localparam int             HOLD_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [1:0][HOLD_W-1:0] hold_cnt_r;
    logic [1:0]             repeat_s;

    // Hold counters start the cycle after the press step so repeats land every REPEAT_CYCLES.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_cnt_r <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!stable_r[k] && !stable_prev_r[k]) begin
                    if (hold_cnt_r[k] == HOLD_LAST) begin
                        hold_cnt_r[k] <= '0;
                    end else begin
                        hold_cnt_r[k] <= hold_cnt_r[k] + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt_r[k] <= '0;
                end
            end
        end
    end

    // Step sources: initial press plus periodic repeats while held.
    always_comb begin
        repeat_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (!stable_r[k] && !stable_prev_r[k] && (hold_cnt_r[k] == HOLD_LAST)) begin
                repeat_s[k] = 1'b1;
            end else begin
                repeat_s[k] = 1'b0;
            end
        end
        step_s = press_s | repeat_s;
    end
`else
    // Single step per accepted press; the repeat interval has no effect in this build.
    always_comb begin
        step_s = 2'b00;
        if (REPEAT_CYCLES > 0) begin
            step_s = press_s;
        end else begin
            step_s = press_s;
        end
    end
`endif

    // Next value: load beats steps, simultaneous up/down cancels, ends wrap or saturate.
    always_comb begin
        next_value_s   = value;
        next_changed_s = 1'b0;
        next_wrap_s    = 1'b0;
        if (load) begin
            next_value_s   = load_val;
            next_changed_s = 1'b1;
        end else if (step_s == 2'b01) begin
            if (value != 4'd15) begin
                next_value_s   = value + 4'd1;
                next_changed_s = 1'b1;
            end else if (WRAP != 0) begin
                next_value_s   = 4'd0;
                next_changed_s = 1'b1;
                next_wrap_s    = 1'b1;
            end else begin
                next_value_s = value;
            end
        end else if (step_s == 2'b10) begin
            if (value != 4'd0) begin
                next_value_s   = value - 4'd1;
                next_changed_s = 1'b1;
            end else if (WRAP != 0) begin
                next_value_s   = 4'd15;
                next_changed_s = 1'b1;
                next_wrap_s    = 1'b1;
            end else begin
                next_value_s = value;
            end
        end else begin
            next_value_s = value;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value   <= 4'd0;
            changed <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            value   <= next_value_s;
            changed <= next_changed_s;
            wrap    <= next_wrap_s;
        end
    end

endmodule

// File: tb/tb_key_step_counter.sv
// Bench for key_step_counter: one wrapping and one saturating instance share stimulus and are
// compared every edge against a run-length based schedule model; honours AUTO_REPEAT_EN.
module tb_key_step_counter;

    localparam int D    = 4;
    localparam int R    = 8;
    localparam int MAXN = 800;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock      = 1'b0;
    logic       resetn     = 1'b1;
    logic       key_up_n   = 1'b1;
    logic       key_down_n = 1'b1;
    logic       load       = 1'b0;
    logic [3:0] load_val   = 4'd0;
    logic [3:0] value_w, value_s;
    logic       changed_w, changed_s, wrap_w, wrap_s;

    int vectors = 0;
    int errors  = 0;
    int n       = 0;

    // Stimulus plan and expected results, indexed by edge number (1..n).
    bit         lvl    [0:1][0:MAXN+1];
    bit         step   [0:1][0:MAXN+1];
    bit         ld     [0:MAXN+1];
    logic [3:0] ldv    [0:MAXN+1];
    logic [3:0] exp_v  [0:1][0:MAXN+1];
    bit         exp_c  [0:1][0:MAXN+1];
    bit         exp_w  [0:1][0:MAXN+1];

    key_step_counter #(.DEBOUNCE_CYCLES(D), .WRAP(1), .REPEAT_CYCLES(R)) dut_w (
        .clock(clock), .resetn(resetn), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .load(load), .load_val(load_val), .value(value_w), .changed(changed_w), .wrap(wrap_w)
    );

    key_step_counter #(.DEBOUNCE_CYCLES(D), .WRAP(0), .REPEAT_CYCLES(R)) dut_s (
        .clock(clock), .resetn(resetn), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .load(load), .load_val(load_val), .value(value_s), .changed(changed_s), .wrap(wrap_s)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int e, input logic [3:0] obs, input logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, e, obs, expv);
        end
    endtask

    task automatic clear_plan(input int len);
        n = len;
        for (int i = 0; i <= MAXN + 1; i++) begin
            lvl[0][i] = 1'b1;
            lvl[1][i] = 1'b1;
            ld[i]     = 1'b0;
            ldv[i]    = 4'd0;
        end
    endtask

    task automatic set_run(input int k, input int from, input int len, input bit lv);
        for (int i = from; i < from + len && i <= n; i++) lvl[k][i] = lv;
    endtask

    task automatic add_step(input int k, input int x);
        if (x <= n) step[k][x] = 1'b1;
    endtask

    // Repeats every R edges after the press step while the key is still accepted as held.
    task automatic add_repeats(input int k, input int fall, input int lim);
        if (AUTO) begin
            for (int x = fall + 1 + R; x <= lim; x += R) add_step(k, x);
        end
    endtask

    // A run of the opposite level lasting at least D samples flips the accepted level;
    // a run sampled from edge s flips at edge s+D+1 and a press steps the value one edge later.
    task automatic compute_steps(input int k);
        int e, s, len, f, fall;
        bit stable, lv;
        for (int i = 0; i <= MAXN + 1; i++) step[k][i] = 1'b0;
        stable = 1'b1;
        fall   = -1;
        e      = 1;
        while (e <= n) begin
            s   = e;
            lv  = lvl[k][s];
            len = 0;
            while (e <= n && lvl[k][e] == lv) begin
                len++;
                e++;
            end
            if (lv != stable && len >= D) begin
                stable = lv;
                f      = s + D + 1;
                if (lv == 1'b0) begin
                    add_step(k, f + 1);
                    fall = f;
                end else begin
                    add_repeats(k, fall, f);
                    fall = -1;
                end
            end
        end
        if (fall >= 0) add_repeats(k, fall, n);
    endtask

    // Instance 0 wraps, instance 1 saturates.
    task automatic compute_expected();
        int v, nv;
        bit c, w, up, dn;
        for (int m = 0; m < 2; m++) begin
            v = 0;
            for (int e = 1; e <= n; e++) begin
                c  = 1'b0;
                w  = 1'b0;
                up = step[0][e];
                dn = step[1][e];
                if (ld[e]) begin
                    v = int'(ldv[e]);
                    c = 1'b1;
                end else if (up != dn) begin
                    nv = up ? v + 1 : v - 1;
                    if (nv >= 0 && nv <= 15) begin
                        v = nv;
                        c = 1'b1;
                    end else if (m == 0) begin
                        v = (nv < 0) ? 15 : 0;
                        c = 1'b1;
                        w = 1'b1;
                    end
                end
                exp_v[m][e] = 4'(v);
                exp_c[m][e] = c;
                exp_w[m][e] = w;
            end
        end
    endtask

    task automatic run_segment();
        compute_steps(0);
        compute_steps(1);
        compute_expected();
        key_up_n   = lvl[0][1];
        key_down_n = lvl[1][1];
        load       = 1'b0;
        load_val   = 4'd0;
        #1 resetn = 1'b0;
        #1;
        check("reset_value_w",   0, value_w,             4'd0);
        check("reset_changed_w", 0, {3'b000, changed_w}, 4'd0);
        check("reset_wrap_w",    0, {3'b000, wrap_w},    4'd0);
        check("reset_value_s",   0, value_s,             4'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int e = 1; e <= n; e++) begin
            key_up_n   = lvl[0][e];
            key_down_n = lvl[1][e];
            load       = ld[e];
            load_val   = ldv[e];
            @(posedge clock);
            #1;
            check("value_w",   e, value_w,             exp_v[0][e]);
            check("changed_w", e, {3'b000, changed_w}, {3'b000, exp_c[0][e]});
            check("wrap_w",    e, {3'b000, wrap_w},    {3'b000, exp_w[0][e]});
            check("value_s",   e, value_s,             exp_v[1][e]);
            check("changed_s", e, {3'b000, changed_s}, {3'b000, exp_c[1][e]});
            check("wrap_s",    e, {3'b000, wrap_s},    {3'b000, exp_w[1][e]});
        end
    endtask

    initial begin
        int pos, len;
        bit lv;

        // Directed segment: held press, bounce, wrap/saturate ends, both keys, load priority, long hold.
        clear_plan(260);
        set_run(0, 1, 14, 1'b0);
        set_run(0, 30, 3, 1'b0);
        set_run(0, 34, 4, 1'b0);
        ld[50] = 1'b1;  ldv[50] = 4'd15;
        set_run(0, 55, 6, 1'b0);
        set_run(1, 70, 6, 1'b0);
        set_run(0, 85, 6, 1'b0);
        set_run(1, 85, 6, 1'b0);
        set_run(0, 100, 6, 1'b0);
        ld[106] = 1'b1; ldv[106] = 4'd9;
        ld[120] = 1'b1; ldv[120] = 4'd0;
        set_run(1, 125, 6, 1'b0);
        ld[140] = 1'b1; ldv[140] = 4'd15;
        set_run(0, 145, 6, 1'b0);
        ld[160] = 1'b1; ldv[160] = 4'd15;
        set_run(0, 180, 44, 1'b0);
        set_run(0, 258, 3, 1'b0);
        run_segment();

        // Reset lands mid-debounce; the partial count must not carry over. Then random traffic.
        clear_plan(700);
        set_run(0, 1, 3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            pos = 20;
            while (pos <= n) begin
                len = int'($urandom_range(1, D + 4));
                lv  = 1'($urandom_range(0, 1));
                set_run(k, pos, len, lv);
                pos += len;
            end
        end
        for (int e = 20; e <= n; e++) begin
            ld[e]  = ($urandom_range(0, 19) == 0);
            ldv[e] = 4'($urandom_range(0, 15));
        end
        run_segment();

        // Up key held through reset release, with a short bounce on the down key.
        clear_plan(40);
        set_run(0, 1, 30, 1'b0);
        set_run(1, 10, 2, 1'b0);
        run_segment();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
